// File: rtl/dff_reg_arbiter_if.sv
// Request/grant/data bundle between N requesters and the shared-register arbiter.
interface dff_reg_arbiter_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N     = 4,
   parameter int unsigned IDW   = 2
);
   logic [N-1:0]       req;
   logic [N*WIDTH-1:0] din;
   logic [N-1:0]       gnt;
   logic [N-1:0]       ack;
   logic [WIDTH-1:0]   Q;
   logic [WIDTH-1:0]   Qbar;
   logic [IDW-1:0]     owner;
   logic               valid;

   // Requester side
   modport master (
      output req, din,
      input  gnt, ack, Q, Qbar, owner, valid
   );

   // Arbiter side
   modport slave (
      input  req, din,
      output gnt, ack, Q, Qbar, owner, valid
   );
endinterface

// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter that serialises N requesters onto one shared WIDTH-bit register.
// A winner is granted for one cycle, then its data is written and acked.
module dff_reg_arbiter #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N     = 4,
   parameter int unsigned IDW   = 2
) (
   input  logic              clk,
   input  logic              rst,
   dff_reg_arbiter_if.slave  bus
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t           state;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   g_idx;
   logic [IDW-1:0]   win_idx;
   logic             win_found;
   logic [N-1:0]     eligible;
   logic [WIDTH-1:0] g_data;
   int unsigned      cand;

   // The requester just acked may still show a stale req; keep it out of this round.
   assign eligible = bus.req & ~bus.ack;

   // First eligible index searching upward from ptr with wrap-around.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int unsigned i = 0; i < N; i++) begin
         cand = 32'(ptr) + i;
         if (cand >= N) begin
            cand = cand - N;
         end
         if (!win_found && eligible[IDW'(cand)]) begin
            win_found = 1'b1;
            win_idx   = IDW'(cand);
         end
      end
   end

   // Data slice belonging to the currently granted requester.
   always_comb begin
      g_data = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (g_idx == IDW'(i)) begin
            g_data = bus.din[i*WIDTH +: WIDTH];
         end
      end
   end

   // Arbitration FSM, pointer and shared register with its complement.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         g_idx     <= '0;
         bus.gnt   <= '0;
         bus.ack   <= '0;
         bus.Q     <= '0;
         bus.Qbar  <= '1;
         bus.owner <= '0;
         bus.valid <= 1'b0;
      end else begin
         bus.ack <= '0;
         case (state)
            IDLE: begin
               if (win_found) begin
                  bus.gnt <= N'(1) << win_idx;
                  g_idx   <= win_idx;
                  state   <= GRANT;
               end
            end
            GRANT: begin
               bus.gnt <= '0;
               state   <= IDLE;
               // A dropped request abandons the grant: nothing is written.
               if (bus.req[g_idx]) begin
                  bus.Q     <= g_data;
                  bus.Qbar  <= ~g_data;
                  bus.ack   <= N'(1) << g_idx;
                  bus.owner <= g_idx;
                  bus.valid <= 1'b1;
                  ptr       <= (g_idx == IDW'(N - 1)) ? '0 : g_idx + IDW'(1);
               end
            end
            default: begin
               bus.gnt <= '0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Directed and randomized checks of dff_reg_arbiter against a transaction-level model.
module tb_dff_reg_arbiter;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned N     = 4;
   localparam int unsigned IDW   = 2;

   logic clk;
   logic rst;
   int   passed;
   int   total;

   // Reference model state: pending grant index (-1 = none), pointer, register, last ack.
   int         m_g;
   int         m_ptr;
   logic [7:0] m_q;
   int         m_owner;
   bit         m_valid;
   logic [3:0] m_ack;

   dff_reg_arbiter_if #(.WIDTH(WIDTH), .N(N), .IDW(IDW)) bus ();

   dff_reg_arbiter #(.WIDTH(WIDTH), .N(N), .IDW(IDW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic model_reset();
      m_g     = -1;
      m_ptr   = 0;
      m_q     = 8'h00;
      m_owner = 0;
      m_valid = 1'b0;
      m_ack   = 4'b0000;
   endtask

   // One transaction step of the arbiter rules, applied at a rising edge.
   task automatic model_update();
      logic [3:0] elig;
      int         w;
      if (m_g < 0) begin
         elig  = bus.req & ~m_ack;
         m_ack = 4'b0000;
         w     = -1;
         for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (m_ptr + k) % 4;
            if (w < 0 && elig[idx]) w = idx;
         end
         m_g = w;
      end else begin
         if (bus.req[m_g]) begin
            m_q     = bus.din[m_g*8 +: 8];
            m_owner = m_g;
            m_valid = 1'b1;
            m_ptr   = (m_g + 1) % 4;
            m_ack   = 4'(1 << m_g);
         end else begin
            m_ack = 4'b0000;
         end
         m_g = -1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic quick_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (bus.Q !== 8'h00 || bus.Qbar !== 8'hFF || bus.gnt !== 4'b0 || bus.ack !== 4'b0 ||
          bus.valid !== 1'b0 || bus.owner !== 2'd0)
         $display("FAIL reset_values: Q=%h Qbar=%h gnt=%b ack=%b valid=%b owner=%0d, want 00 ff 0000 0000 0 0",
                  bus.Q, bus.Qbar, bus.gnt, bus.ack, bus.valid, bus.owner);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_single();
      bus.req = 4'b0100;
      bus.din = 32'h5C_A5_3E_71;
      step();
      total++;
      if (bus.gnt !== 4'b0100 || bus.ack !== 4'b0000)
         $display("FAIL single_grant: gnt=%b ack=%b, want 0100 0000", bus.gnt, bus.ack);
      else passed++;
      step();
      total++;
      if (bus.Q !== 8'hA5 || bus.Qbar !== 8'h5A || bus.ack !== 4'b0100 || bus.owner !== 2'd2 ||
          bus.valid !== 1'b1 || bus.gnt !== 4'b0000)
         $display("FAIL single_write: Q=%h Qbar=%h ack=%b owner=%0d valid=%b gnt=%b, want a5 5a 0100 2 1 0000",
                  bus.Q, bus.Qbar, bus.ack, bus.owner, bus.valid, bus.gnt);
      else passed++;
      bus.req = 4'b0000;
      step();
      total++;
      if (bus.ack !== 4'b0000 || bus.gnt !== 4'b0000)
         $display("FAIL single_ack_pulse: ack=%b gnt=%b, want 0000 0000", bus.ack, bus.gnt);
      else passed++;
   endtask

   // Pointer is 3 here after the single write to index 2.
   task automatic test_wrap_skip();
      bus.req = 4'b0011;
      bus.din = 32'h00_00_B2_B1;
      step();
      total++;
      if (bus.gnt !== 4'b0001)
         $display("FAIL wrap_first_grant: gnt=%b, want 0001", bus.gnt);
      else passed++;
      step();
      total++;
      if (bus.ack !== 4'b0001 || bus.Q !== 8'hB1 || bus.owner !== 2'd0)
         $display("FAIL wrap_first_write: ack=%b Q=%h owner=%0d, want 0001 b1 0", bus.ack, bus.Q, bus.owner);
      else passed++;
      bus.req = 4'b0010;
      step();
      total++;
      if (bus.gnt !== 4'b0010)
         $display("FAIL wrap_second_grant: gnt=%b, want 0010", bus.gnt);
      else passed++;
      step();
      total++;
      if (bus.ack !== 4'b0010 || bus.Q !== 8'hB2 || bus.owner !== 2'd1)
         $display("FAIL wrap_second_write: ack=%b Q=%h owner=%0d, want 0010 b2 1", bus.ack, bus.Q, bus.owner);
      else passed++;
      bus.req = 4'b0000;
      step();
   endtask

   task automatic test_round_robin();
      int         acks [4];
      logic [3:0] exp_ack;
      logic [3:0] exp_gnt;
      logic [7:0] slices [4];
      slices[0] = 8'h11; slices[1] = 8'h22; slices[2] = 8'h33; slices[3] = 8'h44;
      for (int i = 0; i < 4; i++) acks[i] = 0;
      quick_reset();
      bus.req = 4'b1111;
      bus.din = 32'h44_33_22_11;
      for (int k = 1; k <= 16; k++) begin
         step();
         exp_ack = (k % 2 == 0) ? 4'(1 << (((k / 2) - 1) % 4)) : 4'b0000;
         exp_gnt = (k % 2 == 1) ? 4'(1 << (((k - 1) / 2) % 4)) : 4'b0000;
         total++;
         if (bus.ack !== exp_ack || bus.gnt !== exp_gnt)
            $display("FAIL rr_order edge %0d: gnt=%b ack=%b, want %b %b", k, bus.gnt, bus.ack, exp_gnt, exp_ack);
         else passed++;
         if (k % 2 == 0) begin
            total++;
            if (bus.Q !== slices[((k / 2) - 1) % 4])
               $display("FAIL rr_data edge %0d: Q=%h, want %h", k, bus.Q, slices[((k / 2) - 1) % 4]);
            else passed++;
         end
         for (int i = 0; i < 4; i++) if (bus.ack[i] === 1'b1) acks[i]++;
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (acks[i] != 2)
            $display("FAIL rr_fairness req %0d: %0d acks in 16 cycles, want 2", i, acks[i]);
         else passed++;
      end
      bus.req = 4'b0000;
      step();
   endtask

   // Last write was index 3 with 8'h44; pointer is 0.
   task automatic test_abandon();
      bus.req = 4'b0001;
      bus.din = 32'h00_00_00_99;
      step();
      total++;
      if (bus.gnt !== 4'b0001)
         $display("FAIL abandon_grant: gnt=%b, want 0001", bus.gnt);
      else passed++;
      bus.req = 4'b0010;
      bus.din = 32'h00_00_77_99;
      step();
      total++;
      if (bus.ack !== 4'b0000 || bus.gnt !== 4'b0000 || bus.Q !== 8'h44 || bus.Qbar !== 8'hBB ||
          bus.owner !== 2'd3 || bus.valid !== 1'b1)
         $display("FAIL abandon_nowrite: ack=%b gnt=%b Q=%h Qbar=%h owner=%0d valid=%b, want 0000 0000 44 bb 3 1",
                  bus.ack, bus.gnt, bus.Q, bus.Qbar, bus.owner, bus.valid);
      else passed++;
      step();
      total++;
      if (bus.gnt !== 4'b0010)
         $display("FAIL abandon_next_grant: gnt=%b, want 0010", bus.gnt);
      else passed++;
      step();
      total++;
      if (bus.ack !== 4'b0010 || bus.Q !== 8'h77 || bus.owner !== 2'd1)
         $display("FAIL abandon_next_write: ack=%b Q=%h owner=%0d, want 0010 77 1", bus.ack, bus.Q, bus.owner);
      else passed++;
      bus.req = 4'b0000;
      step();
   endtask

   task automatic test_reset_mid_grant();
      bus.req = 4'b0010;
      bus.din = 32'h00_00_C3_00;
      step();
      total++;
      if (bus.gnt !== 4'b0010)
         $display("FAIL rstgrant_grant: gnt=%b, want 0010", bus.gnt);
      else passed++;
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (bus.gnt !== 4'b0000 || bus.ack !== 4'b0000 || bus.Q !== 8'h00 || bus.Qbar !== 8'hFF ||
          bus.valid !== 1'b0)
         $display("FAIL rstgrant_cleared: gnt=%b ack=%b Q=%h Qbar=%h valid=%b, want 0000 0000 00 ff 0",
                  bus.gnt, bus.ack, bus.Q, bus.Qbar, bus.valid);
      else passed++;
      #1;
      rst = 1'b0;
      model_reset();
      step();
      total++;
      if (bus.gnt !== 4'b0010 || bus.ack !== 4'b0000)
         $display("FAIL rstgrant_regrant: gnt=%b ack=%b, want 0010 0000", bus.gnt, bus.ack);
      else passed++;
      step();
      total++;
      if (bus.ack !== 4'b0010 || bus.Q !== 8'hC3 || bus.valid !== 1'b1)
         $display("FAIL rstgrant_write: ack=%b Q=%h valid=%b, want 0010 c3 1", bus.ack, bus.Q, bus.valid);
      else passed++;
      bus.req = 4'b0000;
      step();
   endtask

   task automatic test_random();
      logic [3:0] exp_gnt;
      quick_reset();
      bus.req = 4'b0000;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 4; i++) begin
            if (m_ack[i]) begin
               bus.req[i] = 1'b0;
            end else if (!bus.req[i]) begin
               if ($urandom_range(0, 2) == 0) begin
                  bus.req[i] = 1'b1;
                  bus.din[i*8 +: 8] = 8'($urandom);
               end
            end else if (m_g == i && $urandom_range(0, 15) == 0) begin
               bus.req[i] = 1'b0;
            end
         end
         step();
         exp_gnt = (m_g >= 0) ? 4'(1 << m_g) : 4'b0000;
         total++;
         if (bus.gnt !== exp_gnt || bus.ack !== m_ack)
            $display("FAIL rand_handshake cycle %0d: gnt=%b ack=%b, want %b %b", c, bus.gnt, bus.ack, exp_gnt, m_ack);
         else passed++;
         total++;
         if (bus.Q !== m_q || bus.Qbar !== ~m_q || bus.owner !== 2'(m_owner) || bus.valid !== m_valid)
            $display("FAIL rand_register cycle %0d: Q=%h Qbar=%h owner=%0d valid=%b, want %h %h %0d %b",
                     c, bus.Q, bus.Qbar, bus.owner, bus.valid, m_q, ~m_q, m_owner, m_valid);
         else passed++;
      end
   endtask

   initial begin
      passed  = 0;
      total   = 0;
      rst     = 1'b0;
      bus.req = 4'b0000;
      bus.din = '0;
      model_reset();
      test_reset();
      test_single();
      test_wrap_skip();
      test_round_robin();
      test_abandon();
      test_reset_mid_grant();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/dff_reg_arbiter.md
# dff_reg_arbiter

Round-robin arbiter and write sequencer for a shared WIDTH-bit register built from D flip-flops. It lets N requesters share the register without contention. It takes one request at a time, grants it for one cycle, then loads that requester's data into the register. The block sits between the requesting practical modules and the shared storage, and provides the registered output, its complement and the identity of the last writer.

## Interface
Parameters:
- WIDTH, 8, data width of the shared register
- N, 4, number of requesters; legal range 2..8
- IDW, 2, owner index width; must equal ceil(log2(N))

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  N  per-requester write request; level, held until ack
- din  input  N*WIDTH  requester data; slice i is din[i*WIDTH +: WIDTH]
- gnt  output  N  one-hot grant, registered
- ack  output  N  one-hot, one-cycle write-done pulse, registered
- Q  output  WIDTH  shared register contents
- Qbar  output  WIDTH  bitwise complement of Q, always ~Q
- owner  output  IDW  index of the last successful writer
- valid  output  1  high once any write has completed since reset

## Operation
The block is a two-state FSM with states IDLE and GRANT. It also holds a round-robin pointer ptr (IDW bits, range 0..N-1).

Reset:
- Asserting rst forces state = IDLE, ptr = 0, gnt = 0, ack = 0, Q = 0, Qbar = all ones, owner = 0 and valid = 0.
- These values apply immediately, without waiting for a clock edge.

IDLE state:
- eligible = req & ~ack. Masking out the requester currently acked stops a requester from winning twice on a stale req.
- If eligible is zero, stay in IDLE and hold gnt = 0.
- Otherwise, choose the winner w: the first set bit of eligible, searching ptr, ptr+1, …, wrapping from N-1 to 0.
- On the next edge, set gnt = onehot(w) and go to GRANT.

GRANT state, with granted index g:
- If req[g] is still high:
  - Q <= din slice g, and Qbar <= ~that slice.
  - ack = onehot(g) for exactly one cycle.
  - owner <= g and valid <= 1.
  - ptr <= (g+1) mod N.
- If req[g] has dropped (abandoned request):
  - No write, no ack.
  - Q, owner, valid and ptr are unchanged.
- In both cases, gnt <= 0 and the FSM returns to IDLE.

General rules:
- gnt and ack are never both high in the same cycle.
- At most one bit of each is set.
- din is sampled only on the GRANT-to-IDLE edge. Requesters must hold din stable while gnt is high.
- req bits for indices that are not granted are ignored in GRANT. Those requesters keep waiting, and no request is lost.
- Fairness: with all N requests held continuously, each requester receives exactly one ack in every 2N cycles.

## Timing
- Write latency: req sampled high in IDLE at edge k gives gnt high after edge k. Q is updated and ack goes high after edge k+1.
- Throughput is one write every 2 cycles.
- ack lasts exactly one cycle. A requester deasserts req on the edge after it sees ack. Because of the IDLE mask, the arbiter does not care whether req drops in that cycle.
- Qbar changes on the same edge as Q; it is never derived through a separate combinational delay.
- If rst is asserted during GRANT, the pending write is discarded: Q returns to 0 with no ack.
- If rst deasserts with req already high, arbitration begins on the first rising edge after release.
- Pointer wrap: a grant to index N-1 sets ptr = 0.

## Test plan
Scenarios assume WIDTH=8, N=4, 10 ns clock.
1. Reset: drive rst=1 mid-cycle with no clock edge -> Q=8'h00, Qbar=8'hFF, gnt=0, ack=0, valid=0, owner=0 immediately.
2. Single requester: req=4'b0100 with din slice 2 = 8'hA5 -> gnt=4'b0100 after 1 edge; Q=8'hA5, Qbar=8'h5A, ack=4'b0100, owner=2, valid=1 after 2 edges; ack low on the following cycle.
3. Round-robin: req=4'b1111 held, slices 8'h11/8'h22/8'h33/8'h44 -> ack order 0,1,2,3,0 at 2-cycle spacing; Q follows 11,22,33,44,11.
4. Wrap and skip: with ptr=3 and req=4'b0011 -> index 0 is granted first, then index 1; index 3 is never granted.
5. Abandon: req=4'b0001 and drop req[0] while gnt[0]=1 -> no ack; Q, owner and valid are unchanged; the FSM is back in IDLE; a new req[1] is granted on the next edge.
6. Reset mid-grant: assert rst while gnt=4'b0010 -> gnt=0, Q=0, no ack pulse. After release with req[1] still high, ack[1] arrives 2 edges later.
